// File: rtl/sum_seq_controller.sv
// Control FSM sequencing a 4x8 register file and external adder to compute S = 1+2+...+N; optional SUM_OVF_DETECT_EN adds a sticky overflow flag.
// Latency 3N+5 busy cycles per run, oResult valid one cycle after oDone; no backpressure, iStart is ignored while busy.
module sum_seq_controller (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iStart,
  input  logic [7:0] iLimit,
  input  logic [7:0] iRdData0,
  input  logic [7:0] iRdData1,
  output logic       oWrEn,
  output logic [1:0] oWrAddr,
  output logic [1:0] oRdAddr0,
  output logic [1:0] oRdAddr1,
  output logic       oWrSel,
  output logic [7:0] oImm,
  output logic       oBusy,
  output logic       oDone,
  output logic [7:0] oResult,
  output logic       oOverflow
);

  typedef enum logic [2:0] {
    IDLE, INIT_I, INIT_S, INIT_ONE, CHECK, INC, ACC, DONE
  } state_t;

  typedef struct packed {
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [1:0] rd_addr0;
    logic [1:0] rd_addr1;
    logic       wr_sel;
    logic [7:0] imm;
    logic       busy;
    logic       done;
  } ctrl_t;

  state_t     state;
  ctrl_t      ctrl;
  logic [7:0] limit;

  // Moore decode, applied to the next state so the outputs leave a flop
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != IDLE);
    case (s)
      INIT_I:   begin c.wr_en = 1'b1; c.wr_addr = 2'd1; end
      INIT_S:   begin c.wr_en = 1'b1; c.wr_addr = 2'd2; end
      INIT_ONE: begin c.wr_en = 1'b1; c.wr_addr = 2'd3; c.wr_sel = 1'b1; c.imm = 8'd1; end
      CHECK:    c.rd_addr0 = 2'd1;
      INC:      begin c.rd_addr0 = 2'd1; c.rd_addr1 = 2'd3; c.wr_en = 1'b1; c.wr_addr = 2'd1; end
      ACC:      begin c.rd_addr0 = 2'd2; c.rd_addr1 = 2'd1; c.wr_en = 1'b1; c.wr_addr = 2'd2; end
      DONE:     begin c.rd_addr0 = 2'd2; c.done = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= IDLE;
      ctrl    <= '0;
      limit   <= '0;
      oResult <= '0;
    end else begin
      case (state)
        IDLE: if (iStart) begin
          state <= INIT_I;
          ctrl  <= ctrl_of(INIT_I);
          limit <= iLimit;
        end
        INIT_I:   begin state <= INIT_S;   ctrl <= ctrl_of(INIT_S);   end
        INIT_S:   begin state <= INIT_ONE; ctrl <= ctrl_of(INIT_ONE); end
        INIT_ONE: begin state <= CHECK;    ctrl <= ctrl_of(CHECK);    end
        CHECK: if (iRdData0 < limit) begin
          state <= INC;
          ctrl  <= ctrl_of(INC);
        end else begin
          state <= DONE;
          ctrl  <= ctrl_of(DONE);
        end
        INC:  begin state <= ACC;   ctrl <= ctrl_of(ACC);   end
        ACC:  begin state <= CHECK; ctrl <= ctrl_of(CHECK); end
        DONE: begin
          oResult <= iRdData0;
          state   <= IDLE;
          ctrl    <= ctrl_of(IDLE);
        end
        default: begin state <= IDLE; ctrl <= '0; end
      endcase
    end
  end

  assign oWrEn    = ctrl.wr_en;
  assign oWrAddr  = ctrl.wr_addr;
  assign oRdAddr0 = ctrl.rd_addr0;
  assign oRdAddr1 = ctrl.rd_addr1;
  assign oWrSel   = ctrl.wr_sel;
  assign oImm     = ctrl.imm;
  assign oBusy    = ctrl.busy;
  assign oDone    = ctrl.done;

`ifdef SUM_OVF_DETECT_EN
  logic [8:0] sum9;
  logic       ovf;
  assign sum9 = {1'b0, iRdData0} + {1'b0, iRdData1};

  // Carry out of the external adder on any loop write taints the whole run
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)
      ovf <= 1'b0;
    else if (state == IDLE && iStart)
      ovf <= 1'b0;
    else if ((state == INC || state == ACC) && sum9[8])
      ovf <= 1'b1;
  end
  assign oOverflow = ovf;
`else
  logic unused_rd1;
  assign unused_rd1 = ^iRdData1;
  assign oOverflow  = 1'b0;
`endif

endmodule
